// File: rtl/addsub_seq_cla_pkg.sv
// Shared definitions for the sequential carry-lookahead adder/subtractor.
//   - Operation mode encodings presented on the 'mode' port.
//   - Control FSM state encoding.
package addsub_seq_cla_pkg;

   localparam logic [1:0] MODE_ADD = 2'b00;
   localparam logic [1:0] MODE_SUB = 2'b01;
   localparam logic [1:0] MODE_ADC = 2'b10;
   localparam logic [1:0] MODE_SBC = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_t;

endpackage

// File: rtl/addsub_seq_cla_cla_slice.sv
// K-bit carry-lookahead slice (purely combinational).
// Ports:
//   a   [K-1:0]  slice of operand A
//   bx  [K-1:0]  slice of operand B, already inverted for subtraction
//   cin          carry into bit 0 of the slice
//   sum [K-1:0]  slice sum
//   cv  [K:0]    full carry vector; cv[0] = cin, cv[K] = carry out.
//                cv[K-1] is the carry into the slice MSB, used for overflow.
module cla_slice #(
   parameter int K = 4
) (
   input  logic [K-1:0] a,
   input  logic [K-1:0] bx,
   input  logic         cin,
   output logic [K-1:0] sum,
   output logic [K:0]   cv
);

   logic [K-1:0] g;
   logic [K-1:0] p;

   assign g     = a & bx;
   assign p     = a ^ bx;
   assign cv[0] = cin;

   generate
      for (genvar gi = 0; gi < K; gi++) begin : g_carry
         assign cv[gi+1] = g[gi] | (p[gi] & cv[gi]);
      end
   endgenerate

   assign sum = p ^ cv[K-1:0];

endmodule

// File: rtl/addsub_seq_cla.sv
// Multi-cycle two's-complement adder/subtractor.
// A W-bit operand pair is processed K bits per cycle through a single
// carry-lookahead slice; the carry between slices is held in a register.
// ADC/SBC chain through a carry flag that is updated only when a result is
// taken by the sink, so multi-word arithmetic can be built from a sequence of
// operations.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   in_valid/in_ready  operand handshake (a, b, mode)
//   mode               00 ADD, 01 SUB, 10 ADC, 11 SBC
//   out_valid/out_ready result handshake (s, c, v, z, n)
//   c                  carry out of bit W-1 (for SUB/SBC: 1 = no borrow)
//   v, z, n            signed overflow, zero, negative
module addsub_seq_cla
   import addsub_seq_cla_pkg::*;
#(
   parameter int W = 16,
   parameter int K = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [1:0]   mode,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] s,
   output logic         c,
   output logic         v,
   output logic         z,
   output logic         n
);

   localparam int NSLICE = W / K;
   localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

   state_t          state_q, state_d;
   logic [IDXW-1:0] idx_q, idx_d;
   logic [W-1:0]    a_q, a_d;
   logic [W-1:0]    bx_q, bx_d;
   logic            carry_q, carry_d;
   logic [W-1:0]    s_q, s_d;
   logic            c_q, c_d;
   logic            v_q, v_d;
   logic            z_q, z_d;
   logic            n_q, n_d;
   logic            cflag_q, cflag_d;

   logic [K-1:0]    slice_a;
   logic [K-1:0]    slice_bx;
   logic [K-1:0]    slice_sum;
   logic [K:0]      slice_cv;
   logic [W-1:0]    s_merged;
   logic            last_slice;

   cla_slice #(.K(K)) u_slice (
      .a   (slice_a),
      .bx  (slice_bx),
      .cin (carry_q),
      .sum (slice_sum),
      .cv  (slice_cv)
   );

   assign last_slice = (idx_q == IDXW'(NSLICE - 1));

   // Operand slice selection and write-back of the slice sum into the result.
   // Constant-indexed muxes keep every part-select static.
   always_comb begin
      slice_a  = '0;
      slice_bx = '0;
      s_merged = s_q;
      for (int i = 0; i < NSLICE; i++) begin
         if (idx_q == IDXW'(i)) begin
            slice_a            = a_q[i*K +: K];
            slice_bx           = bx_q[i*K +: K];
            s_merged[i*K +: K] = slice_sum;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      a_d     = a_q;
      bx_d    = bx_q;
      carry_d = carry_q;
      s_d     = s_q;
      c_d     = c_q;
      v_d     = v_q;
      z_d     = z_q;
      n_d     = n_q;
      cflag_d = cflag_q;

      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               a_d  = a;
               // Subtraction is A + ~B + carry; inversion happens once here.
               bx_d = b ^ {W{mode[0]}};
               case (mode)
                  MODE_ADD: carry_d = 1'b0;
                  MODE_SUB: carry_d = 1'b1;
                  MODE_ADC: carry_d = cflag_q;
                  MODE_SBC: carry_d = cflag_q;
                  default:  carry_d = 1'b0;
               endcase
               idx_d   = '0;
               state_d = ST_RUN;
            end
         end

         ST_RUN: begin
            s_d     = s_merged;
            carry_d = slice_cv[K];
            if (last_slice) begin
               c_d     = slice_cv[K];
               // Carry into bit W-1 XOR carry out of bit W-1.
               v_d     = slice_cv[K-1] ^ slice_cv[K];
               z_d     = (s_merged == '0);
               n_d     = s_merged[W-1];
               state_d = ST_DONE;
            end else begin
               idx_d = idx_q + IDXW'(1);
            end
         end

         ST_DONE: begin
            if (out_ready) begin
               cflag_d = c_q;
               state_d = ST_IDLE;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         a_q     <= '0;
         bx_q    <= '0;
         carry_q <= 1'b0;
         s_q     <= '0;
         c_q     <= 1'b0;
         v_q     <= 1'b0;
         z_q     <= 1'b0;
         n_q     <= 1'b0;
         cflag_q <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         a_q     <= a_d;
         bx_q    <= bx_d;
         carry_q <= carry_d;
         s_q     <= s_d;
         c_q     <= c_d;
         v_q     <= v_d;
         z_q     <= z_d;
         n_q     <= n_d;
         cflag_q <= cflag_d;
      end
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign s         = s_q;
   assign c         = c_q;
   assign v         = v_q;
   assign z         = z_q;
   assign n         = n_q;

endmodule

// File: tb/tb_addsub_seq_cla.sv
module tb_addsub_seq_cla;

   localparam int W1 = 16;
   localparam int K1 = 4;
   localparam int W2 = 8;
   localparam int K2 = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;

   logic          in_valid1 = 1'b0, in_ready1, out_valid1, out_ready1 = 1'b0;
   logic [W1-1:0] a1 = '0, b1 = '0, s1;
   logic [1:0]    mode1 = 2'b00;
   logic          c1, v1, z1, n1;

   logic          in_valid2 = 1'b0, in_ready2, out_valid2, out_ready2 = 1'b0;
   logic [W2-1:0] a2 = '0, b2 = '0, s2;
   logic [1:0]    mode2 = 2'b00;
   logic          c2, v2, z2, n2;

   int checks = 0;
   int errors = 0;
   bit mcf1 = 1'b0;   // model carry flag, 16-bit instance
   bit mcf2 = 1'b0;   // model carry flag, 8-bit instance

   always #5 clk = ~clk;

   addsub_seq_cla #(.W(W1), .K(K1)) dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
      .a(a1), .b(b1), .mode(mode1), .out_valid(out_valid1), .out_ready(out_ready1),
      .s(s1), .c(c1), .v(v1), .z(z1), .n(n1));

   addsub_seq_cla #(.W(W2), .K(K2)) dut2 (
      .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
      .a(a2), .b(b2), .mode(mode2), .out_valid(out_valid2), .out_ready(out_ready2),
      .s(s2), .c(c2), .v(v2), .z(z2), .n(n2));

   // Reference: plain integer arithmetic on the operands' unsigned and signed
   // values. Subtraction modes compute a - b - borrow directly.
   function automatic void ref_op(input int w, input logic [1:0] md,
                                  input longint a, input longint b, input bit cf,
                                  output longint s, output bit c, output bit v,
                                  output bit z, output bit n);
      longint m, half, res, sa, sb, exact, cin;
      m    = longint'(1) << w;
      half = m >> 1;
      sa   = (a >= half) ? a - m : a;
      sb   = (b >= half) ? b - m : b;
      if (!md[0]) begin
         cin   = md[1] ? longint'(cf) : 0;
         res   = a + b + cin;
         c     = (res >= m);
         exact = sa + sb + cin;
      end else begin
         cin   = md[1] ? longint'(!cf) : 0;   // borrow in
         res   = a - b - cin;
         c     = (res >= 0);
         exact = sa - sb - cin;
      end
      s = res & (m - 1);
      v = (exact < -half) || (exact > half - 1);
      z = (s == 0);
      n = ((s >> (w - 1)) & 1) != 0;
   endfunction

   // Issue one operation on the 16-bit instance and wait for its result.
   // lat = clock edges from accept until out_valid is seen (21 = timed out).
   task automatic start_op1(input logic [1:0] md, input logic [15:0] a, input logic [15:0] b,
                            output int lat);
      for (int i = 0; i < 20 && !in_ready1; i++) begin
         @(posedge clk); #1;
      end
      mode1 = md; a1 = a; b1 = b; in_valid1 = 1'b1;
      @(posedge clk); #1;
      in_valid1 = 1'b0;
      lat = 0;
      while (lat <= 20) begin
         @(posedge clk); #1;
         lat++;
         if (out_valid1) break;
      end
   endtask

   task automatic finish_op1();
      out_ready1 = 1'b1;
      @(posedge clk); #1;
      out_ready1 = 1'b0;
   endtask

   task automatic test_reset();
      checks++;
      if ({in_ready1, out_valid1} !== 2'b10) begin
         errors++; $display("FAIL reset_hs1 got %b exp 10", {in_ready1, out_valid1});
      end
      checks++;
      if ({s1, c1, v1, z1, n1} !== 20'h0) begin
         errors++; $display("FAIL reset_out1 got %h exp 00000", {s1, c1, v1, z1, n1});
      end
      checks++;
      if ({in_ready2, out_valid2, s2, c2, v2, z2, n2} !== 14'b10_0000_0000_0000) begin
         errors++; $display("FAIL reset_dut2 got %b", {in_ready2, out_valid2, s2, c2, v2, z2, n2});
      end
      $display("reset: in_ready=%b out_valid=%b s=%h", in_ready1, out_valid1, s1);
   endtask

   // Directed 16-bit operation checked against fixed expected values.
   task automatic directed1(input string name, input logic [1:0] md, input logic [15:0] a,
                            input logic [15:0] b, input logic [19:0] exp);
      int lat;
      start_op1(md, a, b, lat);
      $display("op %s mode=%0d a=%h b=%h -> s=%h cvzn=%b%b%b%b lat=%0d",
               name, md, a, b, s1, c1, v1, z1, n1, lat);
      checks++;
      if (lat != K1 * 0 + W1 / K1) begin
         errors++; $display("FAIL %s_latency got %0d exp %0d", name, lat, W1 / K1);
      end
      checks++;
      if ({s1, c1, v1, z1, n1} !== exp) begin
         errors++; $display("FAIL %s_result got %h exp %h", name, {s1, c1, v1, z1, n1}, exp);
      end
      finish_op1();
      mcf1 = exp[3];
   endtask

   task automatic test_add_overflow();
      directed1("add_ovf", 2'b00, 16'h7FFF, 16'h0001, {16'h8000, 4'b0101});
   endtask

   task automatic test_sub();
      directed1("sub_zero", 2'b01, 16'h0005, 16'h0005, {16'h0000, 4'b1010});
      directed1("sub_neg",  2'b01, 16'h0000, 16'h0001, {16'hFFFF, 4'b0001});
   endtask

   task automatic test_chain();
      directed1("chain_add", 2'b00, 16'hFFFF, 16'h0001, {16'h0000, 4'b1010});
      directed1("chain_adc", 2'b10, 16'h0000, 16'h0000, {16'h0001, 4'b0000});
      directed1("chain_sbc", 2'b11, 16'h0003, 16'h0001, {16'h0001, 4'b1000});
   endtask

   task automatic test_back_pressure();
      int lat;
      logic [19:0] held;
      // cflag is 1 here; this result has c=0, so a premature cflag update
      // or an accepted stray operation shows up in the following ADC.
      start_op1(2'b00, 16'h1234, 16'h0001, lat);
      held = {s1, c1, v1, z1, n1};
      checks++;
      if (held !== {16'h1235, 4'b0000}) begin
         errors++; $display("FAIL bp_result got %h exp %h", held, {16'h1235, 4'b0000});
      end
      for (int i = 0; i < 5; i++) begin
         in_valid1 = i[0] ? 1'b0 : 1'b1;
         mode1 = 2'b00; a1 = 16'hFFFF; b1 = 16'hFFFF;
         @(posedge clk); #1;
         $display("bp cycle %0d: in_ready=%b out_valid=%b s=%h", i, in_ready1, out_valid1, s1);
         checks++;
         if ({in_ready1, out_valid1, s1, c1, v1, z1, n1} !== {2'b01, held}) begin
            errors++; $display("FAIL bp_hold%0d got %h exp %h", i,
                               {in_ready1, out_valid1, s1, c1, v1, z1, n1}, {2'b01, held});
         end
      end
      in_valid1 = 1'b0;
      finish_op1();
      mcf1 = 1'b0;
      checks++;
      if ({in_ready1, out_valid1} !== 2'b10) begin
         errors++; $display("FAIL bp_release got %b exp 10", {in_ready1, out_valid1});
      end
      directed1("bp_adc", 2'b10, 16'h0000, 16'h0000, {16'h0000, 4'b0010});
   endtask

   task automatic test_reset_mid_run();
      directed1("pre_rst", 2'b00, 16'hFFFF, 16'h0001, {16'h0000, 4'b1010});
      mode1 = 2'b00; a1 = 16'h0001; b1 = 16'h0001; in_valid1 = 1'b1;
      @(posedge clk); #1;
      in_valid1 = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      mcf1 = 1'b0; mcf2 = 1'b0;
      $display("mid-run reset: in_ready=%b out_valid=%b s=%h", in_ready1, out_valid1, s1);
      checks++;
      if ({in_ready1, out_valid1, s1, c1, v1, z1, n1} !== {2'b10, 20'h0}) begin
         errors++; $display("FAIL midrst_state got %h exp %h",
                            {in_ready1, out_valid1, s1, c1, v1, z1, n1}, {2'b10, 20'h0});
      end
      directed1("post_rst_adc", 2'b10, 16'h0001, 16'h0001, {16'h0002, 4'b0000});
   endtask

   task automatic test_random();
      int lat;
      logic [1:0]  md;
      logic [15:0] ra, rb;
      longint es;
      bit ec, ev, ez, en;
      for (int t = 0; t < 24; t++) begin
         md = 2'($urandom_range(0, 3));
         ra = 16'($urandom);
         rb = 16'($urandom);
         if (t % 6 == 0) rb = ra;                 // force zero results now and then
         ref_op(W1, md, longint'(ra), longint'(rb), mcf1, es, ec, ev, ez, en);
         start_op1(md, ra, rb, lat);
         $display("op rnd%0d mode=%0d a=%h b=%h -> s=%h cvzn=%b%b%b%b lat=%0d",
                  t, md, ra, rb, s1, c1, v1, z1, n1, lat);
         checks++;
         if (lat != W1 / K1) begin
            errors++; $display("FAIL rnd%0d_latency got %0d exp %0d", t, lat, W1 / K1);
         end
         checks++;
         if ({s1, c1, v1, z1, n1} !== {es[15:0], ec, ev, ez, en}) begin
            errors++; $display("FAIL rnd%0d_result got %h exp %h", t,
                               {s1, c1, v1, z1, n1}, {es[15:0], ec, ev, ez, en});
         end
         finish_op1();
         mcf1 = ec;
      end
   endtask

   task automatic test_single_slice();
      int lat;
      logic [1:0] md;
      logic [7:0] ra, rb;
      longint es;
      bit ec, ev, ez, en;
      for (int t = 0; t < 6; t++) begin
         if (t == 0) begin
            md = 2'b00; ra = 8'h80; rb = 8'h80;
         end else begin
            md = 2'($urandom_range(0, 3)); ra = 8'($urandom); rb = 8'($urandom);
         end
         ref_op(W2, md, longint'(ra), longint'(rb), mcf2, es, ec, ev, ez, en);
         if (t == 0) begin
            es = 0; ec = 1'b1; ev = 1'b1; ez = 1'b1; en = 1'b0;
         end
         mode2 = md; a2 = ra; b2 = rb; in_valid2 = 1'b1;
         @(posedge clk); #1;
         in_valid2 = 1'b0;
         lat = 0;
         while (lat <= 20) begin
            @(posedge clk); #1;
            lat++;
            if (out_valid2) break;
         end
         $display("op k=w%0d mode=%0d a=%h b=%h -> s=%h cvzn=%b%b%b%b lat=%0d",
                  t, md, ra, rb, s2, c2, v2, z2, n2, lat);
         checks++;
         if (lat != 1) begin
            errors++; $display("FAIL kw%0d_latency got %0d exp 1", t, lat);
         end
         checks++;
         if ({s2, c2, v2, z2, n2} !== {es[7:0], ec, ev, ez, en}) begin
            errors++; $display("FAIL kw%0d_result got %h exp %h", t,
                               {s2, c2, v2, z2, n2}, {es[7:0], ec, ev, ez, en});
         end
         out_ready2 = 1'b1;
         @(posedge clk); #1;
         out_ready2 = 1'b0;
         mcf2 = ec;
      end
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      test_reset();
      test_add_overflow();
      test_sub();
      test_chain();
      test_back_pressure();
      test_reset_mid_run();
      test_random();
      test_single_slice();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
